// File: rtl/axi_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_responder_pkg
//  Description : Shared widths, timing defaults and FSM encoding for the
//                block-RAM backed stand-in for the DDR user-side AXI port.
//  Revision    : 1.0  initial release
// ============================================================================
package axi_mem_responder_pkg;

    // Beat and address widths of the DDR controller user port being replaced
    localparam int DDR_DATA_WIDTH  = 128;
    localparam int DDR_ADDR_WIDTH  = 28;

    // Timing defaults
    localparam int DDR_RD_LAT      = 2;
    localparam int DDR_INIT_CYCLES = 64;

    // Responder state machine
    typedef enum logic [2:0] {
        S_INIT    = 3'd0,
        S_IDLE    = 3'd1,
        S_WR      = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD      = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/axi_mem_responder_bram.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_bram
//  Description : Single-port RAM, DATA_WIDTH x 2^DEPTH_LOG2, byte-enable write
//                and registered read. The read register only loads on i_re so
//                its output can drive the read data channel directly.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_mem_bram
    import axi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH = DDR_DATA_WIDTH,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_we,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DEPTH_LOG2-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_re,
    output logic [DATA_WIDTH-1:0]   o_rdata
);

    localparam int c_DEPTH = 1 << DEPTH_LOG2;
    localparam int c_BYTES = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_q;

    // Byte-masked write; contents deliberately survive reset
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            for (int b = 0; b < c_BYTES; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
                end
            end
        end
    end

    // Registered read that holds its value between read enables
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : axi_mem_responder
//  Description : AXI-subset responder serving write/read bursts from on-chip
//                RAM in place of the DDR controller. One transaction at a time,
//                round-robin between simultaneous write and read requests.
//  Revision    : 1.0  initial release
// ============================================================================
module axi_mem_responder
    import axi_mem_responder_pkg::*;
#(
    parameter int DATA_WIDTH  = DDR_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DDR_ADDR_WIDTH,
    parameter int DEPTH_LOG2  = 10,
    parameter int INIT_CYCLES = DDR_INIT_CYCLES,
    parameter int RD_LAT      = DDR_RD_LAT
) (
    input  logic                    clk_100M,
    input  logic                    rstn,
    output logic                    ddr_init_done,

    input  logic [ADDR_WIDTH-1:0]   axi_awaddr,
    input  logic [3:0]              axi_awlen,
    input  logic                    axi_awvalid,
    output logic                    axi_awready,

    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    output logic                    axi_wready,
    output logic                    axi_wusero_last,

    input  logic [ADDR_WIDTH-1:0]   axi_araddr,
    input  logic [3:0]              axi_arlen,
    input  logic                    axi_arvalid,
    output logic                    axi_arready,

    output logic [DATA_WIDTH-1:0]   axi_rdata,
    output logic                    axi_rvalid,
    output logic                    axi_rlast
);

    localparam logic [15:0] c_INIT_LAST    = 16'(INIT_CYCLES - 1);
    localparam logic [2:0]  c_RD_WAIT_LOAD = 3'(RD_LAT - 2);

    state_t                r_state;
    logic                  r_init_done;
    logic [15:0]           r_init_cnt;
    logic [DEPTH_LOG2-1:0] r_idx;       // current write beat / next read beat
    logic [3:0]            r_cnt;       // beats remaining after the current one
    logic [2:0]            r_wait;
    logic                  r_last_wr;   // last grant went to the write side
    logic                  r_wready;
    logic                  r_wlast;
    logic                  r_rvalid;
    logic                  r_rlast;

    logic [DEPTH_LOG2-1:0] w_aw_idx;
    logic [DEPTH_LOG2-1:0] w_ar_idx;
    logic                  w_idle;
    logic                  w_grant_wr;
    logic                  w_grant_rd;
    logic                  w_rd_fire;
    logic                  w_ram_we;
    logic [DEPTH_LOG2-1:0] w_ram_addr;
    logic [DATA_WIDTH-1:0] w_ram_q;
    logic                  w_unused_addr_bits;

    // One beat spans 8 address units, so the word index starts at bit 3
    assign w_aw_idx = axi_awaddr[DEPTH_LOG2+2:3];
    assign w_ar_idx = axi_araddr[DEPTH_LOG2+2:3];
    assign w_unused_addr_bits = ^{axi_awaddr[ADDR_WIDTH-1:DEPTH_LOG2+3], axi_awaddr[2:0],
                                  axi_araddr[ADDR_WIDTH-1:DEPTH_LOG2+3], axi_araddr[2:0]};

    // Ready pulses are a decode of IDLE and the live valids, so they can never
    // appear without the matching valid and grant in the same cycle
    assign w_idle      = (r_state == S_IDLE);
    assign w_grant_wr  = w_idle && axi_awvalid && (!axi_arvalid || !r_last_wr);
    assign w_grant_rd  = w_idle && axi_arvalid && !w_grant_wr;
    assign axi_awready = w_grant_wr;
    assign axi_arready = w_grant_rd;

    // RAM read is launched one cycle before each beat appears on rvalid
    assign w_rd_fire = ((r_state == S_RD_WAIT) && (r_wait == 3'd0)) ||
                       ((r_state == S_RD) && (r_cnt != 4'd0)) ||
                       ((RD_LAT == 1) && w_grant_rd);
    assign w_ram_we   = (r_state == S_WR) && r_wready;
    assign w_ram_addr = w_idle ? w_ar_idx : r_idx;

    axi_mem_bram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_bram (
        .i_clk   (clk_100M),
        .i_rst_n (rstn),
        .i_we    (w_ram_we),
        .i_be    (axi_wstrb),
        .i_addr  (w_ram_addr),
        .i_wdata (axi_wdata),
        .i_re    (w_rd_fire),
        .o_rdata (w_ram_q)
    );

    // Responder FSM: init delay, arbitration, write beats, read latency, read beats
    always_ff @(posedge clk_100M or negedge rstn) begin
        if (!rstn) begin
            r_state     <= S_INIT;
            r_init_done <= 1'b0;
            r_init_cnt  <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_last_wr   <= 1'b0;
            r_wready    <= 1'b0;
            r_wlast     <= 1'b0;
            r_rvalid    <= 1'b0;
            r_rlast     <= 1'b0;
        end else begin
            case (r_state)
                S_INIT: begin
                    if (r_init_cnt == c_INIT_LAST) begin
                        r_init_done <= 1'b1;
                        r_state     <= S_IDLE;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (w_grant_wr) begin
                        r_last_wr <= 1'b1;
                        r_idx     <= w_aw_idx;
                        r_cnt     <= axi_awlen;
                        r_wready  <= 1'b1;
                        r_wlast   <= (axi_awlen == 4'd0);
                        r_state   <= S_WR;
                    end else if (w_grant_rd) begin
                        r_last_wr <= 1'b0;
                        r_cnt     <= axi_arlen;
                        if (RD_LAT == 1) begin
                            r_idx    <= w_ar_idx + 1'b1;
                            r_rvalid <= 1'b1;
                            r_rlast  <= (axi_arlen == 4'd0);
                            r_state  <= S_RD;
                        end else begin
                            r_idx   <= w_ar_idx;
                            r_wait  <= c_RD_WAIT_LOAD;
                            r_state <= S_RD_WAIT;
                        end
                    end
                end
                S_WR: begin
                    if (r_cnt == 4'd0) begin
                        r_wready <= 1'b0;
                        r_wlast  <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_idx   <= r_idx + 1'b1;
                        r_wlast <= (r_cnt == 4'd1);
                    end
                end
                S_RD_WAIT: begin
                    if (r_wait == 3'd0) begin
                        r_idx    <= r_idx + 1'b1;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (r_cnt == 4'd0);
                        r_state  <= S_RD;
                    end else begin
                        r_wait <= r_wait - 1'b1;
                    end
                end
                S_RD: begin
                    if (r_cnt == 4'd0) begin
                        r_rvalid <= 1'b0;
                        r_rlast  <= 1'b0;
                        r_state  <= S_IDLE;
                    end else begin
                        r_cnt   <= r_cnt - 1'b1;
                        r_idx   <= r_idx + 1'b1;
                        r_rlast <= (r_cnt == 4'd1);
                    end
                end
                default: r_state <= S_INIT;
            endcase
        end
    end

    assign ddr_init_done   = r_init_done;
    assign axi_wready      = r_wready;
    assign axi_wusero_last = r_wlast;
    assign axi_rvalid      = r_rvalid;
    assign axi_rlast       = r_rlast;
    assign axi_rdata       = w_ram_q;

endmodule
`default_nettype wire

// File: tb/tb_axi_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_mem_responder
//  Description : Directed self-checking bench for axi_mem_responder
//                (DEPTH_LOG2=4 so the wrap case is reachable).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_axi_mem_responder;

    logic         clk_100M = 1'b0;
    logic         rstn;
    logic         ddr_init_done;
    logic [27:0]  axi_awaddr;
    logic [3:0]   axi_awlen;
    logic         axi_awvalid;
    logic         axi_awready;
    logic [127:0] axi_wdata;
    logic [15:0]  axi_wstrb;
    logic         axi_wready;
    logic         axi_wusero_last;
    logic [27:0]  axi_araddr;
    logic [3:0]   axi_arlen;
    logic         axi_arvalid;
    logic         axi_arready;
    logic [127:0] axi_rdata;
    logic         axi_rvalid;
    logic         axi_rlast;

    int n_pass  = 0;
    int n_total = 0;

    localparam logic [127:0] c_ONES = {128{1'b1}};

    axi_mem_responder #(
        .DATA_WIDTH  (128),
        .ADDR_WIDTH  (28),
        .DEPTH_LOG2  (4),
        .INIT_CYCLES (64),
        .RD_LAT      (2)
    ) dut (
        .clk_100M        (clk_100M),
        .rstn            (rstn),
        .ddr_init_done   (ddr_init_done),
        .axi_awaddr      (axi_awaddr),
        .axi_awlen       (axi_awlen),
        .axi_awvalid     (axi_awvalid),
        .axi_awready     (axi_awready),
        .axi_wdata       (axi_wdata),
        .axi_wstrb       (axi_wstrb),
        .axi_wready      (axi_wready),
        .axi_wusero_last (axi_wusero_last),
        .axi_araddr      (axi_araddr),
        .axi_arlen       (axi_arlen),
        .axi_arvalid     (axi_arvalid),
        .axi_arready     (axi_arready),
        .axi_rdata       (axi_rdata),
        .axi_rvalid      (axi_rvalid),
        .axi_rlast       (axi_rlast)
    );

    always #5 clk_100M = ~clk_100M;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Called at the negedge of the write-address handshake cycle
    task automatic wr_beats(input logic [3:0] len, input logic [127:0] base,
                            input logic [15:0] strb, input string tag);
        @(negedge clk_100M);
        axi_awvalid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            chk({tag, " wready"}, axi_wready, 1'b1);
            chk({tag, " wlast"}, axi_wusero_last, (k == int'(len)));
            axi_wdata = base + 128'(k);
            axi_wstrb = strb;
            @(negedge clk_100M);
        end
        chk({tag, " wready_end"}, axi_wready, 1'b0);
        axi_wstrb = '0;
    endtask

    task automatic do_write(input logic [27:0] addr, input logic [3:0] len,
                            input logic [127:0] base, input logic [15:0] strb, input string tag);
        int n;
        axi_awaddr  = addr;
        axi_awlen   = len;
        axi_awvalid = 1'b1;
        #1;
        n = 0;
        while (!axi_awready && n < 50) begin
            @(negedge clk_100M);
            n++;
        end
        chk({tag, " awready"}, axi_awready, 1'b1);
        wr_beats(len, base, strb, tag);
    endtask

    task automatic do_read(input logic [27:0] addr, input logic [3:0] len,
                           input logic [127:0] base, input string tag);
        int n;
        axi_araddr  = addr;
        axi_arlen   = len;
        axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!axi_arready && n < 50) begin
            @(negedge clk_100M);
            n++;
        end
        chk({tag, " arready"}, axi_arready, 1'b1);
        @(negedge clk_100M);
        axi_arvalid = 1'b0;
        chk({tag, " rvalid_lat"}, axi_rvalid, 1'b0);
        @(negedge clk_100M);
        for (int k = 0; k <= int'(len); k++) begin
            chk({tag, " rvalid"}, axi_rvalid, 1'b1);
            chk({tag, " rlast"}, axi_rlast, (k == int'(len)));
            chk({tag, " rdata"}, axi_rdata, base + 128'(k));
            @(negedge clk_100M);
        end
        chk({tag, " rvalid_end"}, axi_rvalid, 1'b0);
        chk({tag, " rdata_hold"}, axi_rdata, base + 128'(len));
    endtask

    initial begin
        int aw_seen;
        int n;
        rstn        = 1'b0;
        axi_awaddr  = '0;
        axi_awlen   = '0;
        axi_awvalid = 1'b0;
        axi_wdata   = '0;
        axi_wstrb   = '0;
        axi_araddr  = '0;
        axi_arlen   = '0;
        axi_arvalid = 1'b0;

        // Reset values
        repeat (2) @(negedge clk_100M);
        chk("rst init_done", ddr_init_done, 1'b0);
        chk("rst awready", axi_awready, 1'b0);
        chk("rst wready", axi_wready, 1'b0);
        chk("rst wlast", axi_wusero_last, 1'b0);
        chk("rst arready", axi_arready, 1'b0);
        chk("rst rvalid", axi_rvalid, 1'b0);
        chk("rst rlast", axi_rlast, 1'b0);
        chk("rst rdata", axi_rdata, 128'h0);

        // Init delay with an early write request pending from cycle 10
        @(negedge clk_100M);
        rstn = 1'b1;
        aw_seen = 0;
        for (int k = 1; k <= 64; k++) begin
            @(negedge clk_100M);
            if (k < 64 && axi_awready) aw_seen++;
            if (k == 10) begin
                axi_awaddr  = 28'h40;
                axi_awlen   = 4'd3;
                axi_awvalid = 1'b1;
            end
            if (k == 63) chk("init done@63", ddr_init_done, 1'b0);
        end
        chk("init done@64", ddr_init_done, 1'b1);
        chk("init no early awready", 128'(aw_seen), 128'd0);
        chk("init awready@64", axi_awready, 1'b1);
        wr_beats(4'd3, 128'd1, 16'hFFFF, "wr40");
        do_read(28'h40, 4'd3, 128'd1, "rd40");

        // Partial strobe
        do_write(28'h0, 4'd0, c_ONES, 16'hFFFF, "wrFF");
        do_write(28'h0, 4'd0, 128'd0, 16'h0001, "wrB0");
        do_read(28'h0, 4'd0, {c_ONES[127:8], 8'h00}, "rdB0");

        // Round robin: W (reset last=read), then R, then W
        axi_awaddr = 28'h20; axi_awlen = 4'd0; axi_awvalid = 1'b1;
        axi_araddr = 28'h40; axi_arlen = 4'd0; axi_arvalid = 1'b1;
        #1;
        chk("rr1 awready", axi_awready, 1'b1);
        chk("rr1 arready", axi_arready, 1'b0);
        @(negedge clk_100M);
        axi_awvalid = 1'b0;
        chk("rr1 wready", axi_wready, 1'b1);
        chk("rr1 arready_wr", axi_arready, 1'b0);
        axi_wdata = 128'h55; axi_wstrb = 16'hFFFF;
        @(negedge clk_100M);
        axi_wstrb = '0;
        axi_awaddr = 28'h28; axi_awlen = 4'd0; axi_awvalid = 1'b1;
        #1;
        chk("rr2 arready", axi_arready, 1'b1);
        chk("rr2 awready", axi_awready, 1'b0);
        @(negedge clk_100M);
        axi_arvalid = 1'b0;
        chk("rr2 awready_wait", axi_awready, 1'b0);
        @(negedge clk_100M);
        chk("rr2 rvalid", axi_rvalid, 1'b1);
        chk("rr2 rdata", axi_rdata, 128'd1);
        chk("rr2 rlast", axi_rlast, 1'b1);
        @(negedge clk_100M);
        chk("rr3 awready", axi_awready, 1'b1);
        wr_beats(4'd0, 128'h66, 16'hFFFF, "rr3");
        do_read(28'h20, 4'd0, 128'h55, "rd20");
        do_read(28'h28, 4'd0, 128'h66, "rd28");

        // Wrap: index 15 then 0
        do_write(28'h78, 4'd1, 128'hA0, 16'hFFFF, "wrap");
        do_read(28'h0, 4'd0, 128'hA1, "rdwrap0");
        do_read(28'h78, 4'd1, 128'hA0, "rdwrap15");

        // Zero strobe still counts as a beat and leaves data untouched
        do_write(28'h40, 4'd0, 128'h99, 16'h0000, "wrz");

        // Reset during the 3rd beat of a 16-beat read
        axi_araddr = 28'h0; axi_arlen = 4'd15; axi_arvalid = 1'b1;
        #1;
        n = 0;
        while (!axi_arready && n < 50) begin
            @(negedge clk_100M);
            n++;
        end
        chk("rst16 arready", axi_arready, 1'b1);
        @(negedge clk_100M);
        axi_arvalid = 1'b0;
        repeat (3) @(negedge clk_100M);
        chk("rst16 rvalid beat3", axi_rvalid, 1'b1);
        rstn = 1'b0;
        #1;
        chk("rst16 rvalid", axi_rvalid, 1'b0);
        chk("rst16 rlast", axi_rlast, 1'b0);
        chk("rst16 rdata", axi_rdata, 128'h0);
        chk("rst16 init_done", ddr_init_done, 1'b0);
        repeat (2) @(negedge clk_100M);
        rstn = 1'b1;
        n = 0;
        while (!ddr_init_done && n < 200) begin
            @(negedge clk_100M);
            n++;
        end
        chk("rst16 reinit", ddr_init_done, 1'b1);
        do_read(28'h40, 4'd3, 128'd1, "rdold");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
